// File: rtl/acp_pkg.sv
// Shared AXI constants, FSM state type and burst-length helper for the ACP burst writer.
package acp_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ADDR = 3'd1,
        DATA = 3'd2,
        RESP = 3'd3,
        FIN  = 3'd4
    } acp_state_e;

    localparam logic [2:0] SIZE_64B   = 3'd3;
    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [3:0] ACP_CACHE  = 4'b1111;
    localparam logic [4:0] ACP_USER   = 5'b00001;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    // AWLEN for the next burst: a full burst while enough words remain, else the tail.
    function automatic logic [7:0] burst_awlen(input logic [31:0] remaining,
                                               input int unsigned burst_len);
        if (remaining >= burst_len) return 8'(burst_len - 1);
        return 8'(remaining - 32'd1);
    endfunction

endpackage

// File: rtl/acp_burst_writer_if.sv
// AXI3 write-channel bundle between the burst writer (master) and the ACP port (slave).
interface acp_burst_writer_if;
    logic [31:0] M_AXI_AWADDR;
    logic [7:0]  M_AXI_AWLEN;
    logic [2:0]  M_AXI_AWSIZE;
    logic [1:0]  M_AXI_AWBURST;
    logic [3:0]  M_AXI_AWCACHE;
    logic [4:0]  M_AXI_AWUSER;
    logic [2:0]  M_AXI_AWPROT;
    logic        M_AXI_AWVALID;
    logic        M_AXI_AWREADY;
    logic [63:0] M_AXI_WDATA;
    logic [7:0]  M_AXI_WSTRB;
    logic        M_AXI_WLAST;
    logic        M_AXI_WVALID;
    logic        M_AXI_WREADY;
    logic [1:0]  M_AXI_BRESP;
    logic        M_AXI_BVALID;
    logic        M_AXI_BREADY;

    modport master (
        output M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_AWSIZE, M_AXI_AWBURST, M_AXI_AWCACHE,
               M_AXI_AWUSER, M_AXI_AWPROT, M_AXI_AWVALID,
               M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WLAST, M_AXI_WVALID, M_AXI_BREADY,
        input  M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BRESP, M_AXI_BVALID
    );

    modport slave (
        input  M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_AWSIZE, M_AXI_AWBURST, M_AXI_AWCACHE,
               M_AXI_AWUSER, M_AXI_AWPROT, M_AXI_AWVALID,
               M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WLAST, M_AXI_WVALID, M_AXI_BREADY,
        output M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BRESP, M_AXI_BVALID
    );
endinterface

// File: rtl/acp_burst_writer.sv
// Streams num_words 64-bit words into DDR over the ACP port as a chain of INCR bursts,
// one burst outstanding at a time.
module acp_burst_writer
    import acp_pkg::*;
#(
    parameter int BURST_LEN = 16,
    parameter int LEN_W     = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [31:0]        base_addr,
    input  logic [LEN_W-1:0]   num_words,
    output logic               busy,
    output logic               done,
    output logic               err,
    input  logic [63:0]        s_tdata,
    input  logic               s_tvalid,
    output logic               s_tready,
    acp_burst_writer_if.master m_axi,
    output acp_state_e         dbg_state
);

    // Every channel transfers on the cycle where valid && ready; a raised valid and its
    // payload are held until that cycle. The W channel is a pure pass-through of the stream.

    acp_state_e       state_q, state_d;
    logic [31:0]      addr_q, addr_d;
    logic [LEN_W-1:0] remaining_q, remaining_d;
    logic [7:0]       awlen_q, awlen_d;
    logic [7:0]       beat_q, beat_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             awvalid_q, awvalid_d;
    logic             bready_q, bready_d;

    logic [8:0]       beats;
    logic             in_data;
    logic             last_beat;

    assign beats     = {1'b0, awlen_q} + 9'd1;
    assign in_data   = (state_q == DATA);
    assign last_beat = (beat_q == awlen_q);

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        awlen_d     = awlen_q;
        beat_d      = beat_q;
        err_d       = err_q;
        done_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d      = base_addr;
                    remaining_d = num_words;
                    awlen_d     = burst_awlen(32'(num_words), BURST_LEN);
                    beat_d      = 8'd0;
                    err_d       = 1'b0;
                    state_d     = (num_words == '0) ? FIN : ADDR;
                end
            end
            ADDR: begin
                if (m_axi.M_AXI_AWREADY) state_d = DATA;
            end
            DATA: begin
                if (s_tvalid && m_axi.M_AXI_WREADY) begin
                    if (last_beat) begin
                        beat_d  = 8'd0;
                        state_d = RESP;
                    end else begin
                        beat_d = beat_q + 8'd1;
                    end
                end
            end
            RESP: begin
                if (m_axi.M_AXI_BVALID) begin
                    if (m_axi.M_AXI_BRESP != RESP_OKAY) err_d = 1'b1;
                    addr_d      = addr_q + {20'd0, beats, 3'd0};
                    remaining_d = remaining_q - LEN_W'(beats);
                    awlen_d     = burst_awlen(32'(remaining_d), BURST_LEN);
                    state_d     = (remaining_d != '0) ? ADDR : FIN;
                end
            end
            FIN: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Control outputs are registered from the next state so they align with it.
        busy_d    = (state_d != IDLE);
        awvalid_d = (state_d == ADDR);
        bready_d  = (state_d == RESP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= 32'd0;
            remaining_q <= '0;
            awlen_q     <= 8'd0;
            beat_q      <= 8'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            awvalid_q   <= 1'b0;
            bready_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            awlen_q     <= awlen_d;
            beat_q      <= beat_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            awvalid_q   <= awvalid_d;
            bready_q    <= bready_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign dbg_state = state_q;
    assign s_tready  = in_data && m_axi.M_AXI_WREADY;

    assign m_axi.M_AXI_AWADDR  = addr_q;
    assign m_axi.M_AXI_AWLEN   = awlen_q;
    assign m_axi.M_AXI_AWSIZE  = SIZE_64B;
    assign m_axi.M_AXI_AWBURST = BURST_INCR;
    assign m_axi.M_AXI_AWCACHE = ACP_CACHE;
    assign m_axi.M_AXI_AWUSER  = ACP_USER;
    assign m_axi.M_AXI_AWPROT  = 3'd0;
    assign m_axi.M_AXI_AWVALID = awvalid_q;
    assign m_axi.M_AXI_WDATA   = in_data ? s_tdata : 64'd0;
    assign m_axi.M_AXI_WSTRB   = in_data ? 8'hFF : 8'h00;
    assign m_axi.M_AXI_WLAST   = in_data && last_beat;
    assign m_axi.M_AXI_WVALID  = in_data && s_tvalid;
    assign m_axi.M_AXI_BREADY  = bready_q;

endmodule

// File: doc/acp_burst_writer.md
ACP_BURST_WRITER -- requirements
Module: acp_burst_writer

Interface
REQ-001 SHALL have parameter BURST_LEN, default 16, meaning beats per full AXI write burst (1..16).
REQ-002 SHALL have parameter LEN_W, default 16, meaning the width of the transfer word count.
REQ-003 SHALL have port clk, input, 1, the single clock, the PS FCLK_CLK0 domain.
REQ-004 SHALL have port rst_n, input, 1, reset: one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port start, input, 1, single-cycle transfer request.
REQ-006 SHALL have port base_addr, input, 32, byte address in DDR, aligned to BURST_LEN*8.
REQ-007 SHALL have port num_words, input, LEN_W, count of 64-bit words to write.
REQ-008 SHALL have port busy, output, 1, high from accepted start until done.
REQ-009 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-010 SHALL have port err, output, 1, sticky flag set by any non-OKAY BRESP and cleared on accepted start.
REQ-011 SHALL have ports s_tdata (input, 64), s_tvalid (input, 1) and s_tready (output, 1), the upstream data stream.
REQ-012 SHALL have ports M_AXI_AWADDR (output, 32), AWLEN (output, 8), AWSIZE (output, 3), AWBURST (output, 2), AWCACHE (output, 4), AWUSER (output, 5), AWPROT (output, 3), AWVALID (output, 1) and AWREADY (input, 1).
REQ-013 SHALL have ports M_AXI_WDATA (output, 64), WSTRB (output, 8), WLAST (output, 1), WVALID (output, 1) and WREADY (input, 1).
REQ-014 SHALL have ports M_AXI_BRESP (input, 2), BVALID (input, 1) and BREADY (output, 1).

Function
REQ-015 SHALL implement the states IDLE, ADDR, DATA, RESP and FIN.
REQ-016 SHALL accept start only in IDLE; start is ignored while busy.
REQ-017 SHALL, on accepted start, latch the address and remaining count and go to ADDR.
REQ-018 SHALL, on accepted start with num_words==0, go to FIN and pulse done one cycle later, with no AXI traffic.
REQ-019 SHALL, in ADDR, assert AWVALID with AWLEN = min(remaining, BURST_LEN)-1.
REQ-020 SHALL, in ADDR, drive AWSIZE=3, AWBURST=INCR(1), AWCACHE=4'b1111, AWUSER=5'b00001 and AWPROT=0, all held stable until AWREADY.
REQ-021 SHALL go to DATA on AWVALID&&AWREADY.
REQ-022 SHALL hold only one burst outstanding; no new AW is issued before the prior B response.
REQ-023 SHALL, in DATA, set WVALID=s_tvalid, s_tready=WREADY, WDATA=s_tdata and WSTRB=8'hFF; a beat transfers when s_tvalid&&WREADY.
REQ-024 SHALL assert WLAST on the beat whose index equals the latched AWLEN; after that beat it goes to RESP.
REQ-025 SHALL hold s_tready=0 outside DATA.
REQ-026 SHALL, in RESP, assert BREADY and sample BRESP on BVALID.
REQ-027 SHALL, in RESP, set err if BRESP!=0, then add burst_beats*8 to the address and subtract burst_beats from remaining.
REQ-028 SHALL, after RESP, return to ADDR if remaining>0, else go to FIN.
REQ-029 SHALL, in FIN, pulse done for exactly one cycle and return to IDLE; busy deasserts in the same cycle as done.
REQ-030 SHALL continue the transfer after an error response; err does not abort.
REQ-031 SHALL perform address arithmetic modulo 2^32; the aligned base ensures no burst crosses a 4 KB boundary.
REQ-032 SHALL give the first AWVALID a latency of 1 cycle after start.

Reset
REQ-033 SHALL, on rst_n low, asynchronously force state IDLE, with busy, done, err, AWVALID, WVALID, WLAST, BREADY and s_tready all 0 and the counters 0.
REQ-034 SHALL, on reset mid-transfer, abandon the transfer with no done pulse; the system-level reset of the interconnect is the recovery mechanism.

Structure
REQ-035 SHALL take the AXI constants (SIZE_64B, BURST_INCR, ACP_CACHE, ACP_USER, RESP_OKAY) and the state enum from shared package acp_pkg.
REQ-036 SHALL contain no sub-module; the datapath is counters plus the FSM.

Verification
REQ-037 SHALL verify: base 0x1000_0000, num_words=16, all ready high -> one AW (AWLEN=15), 16 beats with WLAST on the 16th, then done; err=0.
REQ-038 SHALL verify: num_words=37 -> AWs at 0x...000, 0x...080 and 0x...100 with AWLEN 15, 15 and 4; 37 beats in total; single done.
REQ-039 SHALL verify: random WREADY/s_tvalid/AWREADY/BVALID stalls -> data order preserved, AW fields stable while AWVALID is high, no beat lost or duplicated.
REQ-040 SHALL verify: SLVERR on the 2nd of 3 bursts -> all 3 bursts complete, err=1 at done, and err is cleared by the next start.
REQ-041 SHALL verify: num_words=0 -> done 2 cycles after start and no AWVALID ever asserted; a start while busy is ignored.
REQ-042 SHALL verify: rst_n low during DATA -> all outputs 0 immediately, no done, and a new start after reset works.
